// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding,
// owner identifiers and the legal memory-latency window.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic OWN_CU = 1'b0;
  localparam logic OWN_LD = 1'b1;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned WAIT_CNT_W  = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the requests;
// last_grant only moves when the caller accepts a grant.
import mem_port_arbiter_pkg::*;

module rr_arb2 #(
  parameter int unsigned LD_FIRST_TIE = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       valid_o,
  output logic       grant_o
);

  logic last_q;

  always_comb begin
    valid_o = |req_i;
    if (req_i[OWN_CU] && req_i[OWN_LD]) grant_o = ~last_q;
    else                                grant_o = req_i[OWN_LD] ? OWN_LD : OWN_CU;
  end

  // Reset value is the side that must lose the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i)                last_q <= (LD_FIRST_TIE != 0) ? OWN_CU : OWN_LD;
    else if (en_i && valid_o)   last_q <= grant_o;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the control unit and the program
// loader; sequences enable/write-enable, MDR load and the done handshakes.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned LD_FIRST_TIE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic read,
  input  logic write,
  input  logic ld_req,
  input  logic ld_we,
  output logic cu_done,
  output logic ld_done,
  output logic mem_en,
  output logic mem_we,
  output logic addr_sel,
  output logic mdr_ld,
  output logic busy,
  output logic err
);

  localparam int unsigned LAT = (MEM_LATENCY < MEM_LAT_MIN) ? MEM_LAT_MIN :
                                (MEM_LATENCY > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LATENCY;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(LAT - 1);

  state_e                state_q;
  logic                  owner_q;
  logic                  we_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  err_q;
  logic                  cu_done_q, ld_done_q, mem_en_q, mem_we_q;
  logic                  addr_sel_q, mdr_ld_q, busy_q;

  logic arb_valid, arb_grant, arb_en, op_we, finish;
  logic [1:0] arb_req;

  assign arb_req = {ld_req, read | write};
  assign arb_en  = (state_q == ST_IDLE);

  rr_arb2 #(.LD_FIRST_TIE(LD_FIRST_TIE)) u_arb (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (arb_req),
    .en_i    (arb_en),
    .valid_o (arb_valid),
    .grant_o (arb_grant)
  );

  always_comb begin
    op_we  = (arb_grant == OWN_LD) ? ld_we : write;
    finish = ((state_q == ST_ACCESS) && (we_q || (LAT == 1))) ||
             ((state_q == ST_WAIT) && (wait_cnt_q == WAIT_CNT_W'(1)));
  end

  // Outputs are registered alongside the state, so each is set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_CU;
      we_q       <= 1'b0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      cu_done_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      mdr_ld_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cu_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      mdr_ld_q  <= 1'b0;
      if (finish) begin
        state_q   <= ST_DONE;
        mem_en_q  <= 1'b0;
        mem_we_q  <= 1'b0;
        cu_done_q <= (owner_q == OWN_CU);
        ld_done_q <= (owner_q == OWN_LD);
        mdr_ld_q  <= (owner_q == OWN_CU) && !we_q;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (arb_valid) begin
              state_q    <= ST_ACCESS;
              owner_q    <= arb_grant;
              we_q       <= op_we;
              mem_en_q   <= 1'b1;
              mem_we_q   <= op_we;
              addr_sel_q <= arb_grant;
              busy_q     <= 1'b1;
              if ((arb_grant == OWN_CU) && read && write) err_q <= 1'b1;
            end
          end
          ST_ACCESS: begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= WAIT_LOAD;
            mem_we_q   <= 1'b0;
          end
          ST_WAIT: begin
            wait_cnt_q <= wait_cnt_q - WAIT_CNT_W'(1);
          end
          ST_DONE: begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            addr_sel_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cu_done  = cu_done_q;
  assign ld_done  = ld_done_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign addr_sel = addr_sel_q;
  assign mdr_ld   = mdr_ld_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each grant's timeline;
// a negedge monitor compares every cycle and pops completions on done pulses.
module tb_mem_port_arbiter;

  localparam int L   = 2;
  localparam int INF = 32'h7fffffff;

  logic clk = 1'b0;
  logic reset, read, write, ld_req, ld_we;
  logic cu_done, ld_done, mem_en, mem_we, addr_sel, mdr_ld, busy, err;
  logic r1, w1, lr1, lw1;
  logic cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L), .LD_FIRST_TIE(0)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .ld_req(ld_req), .ld_we(ld_we),
    .cu_done(cu_done), .ld_done(ld_done), .mem_en(mem_en), .mem_we(mem_we),
    .addr_sel(addr_sel), .mdr_ld(mdr_ld), .busy(busy), .err(err)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .LD_FIRST_TIE(1)) dut1 (
    .clk(clk), .reset(reset), .read(r1), .write(w1), .ld_req(lr1), .ld_we(lw1),
    .cu_done(cu_done1), .ld_done(ld_done1), .mem_en(mem_en1), .mem_we(mem_we1),
    .addr_sel(addr_sel1), .mdr_ld(mdr_ld1), .busy(busy1), .err(err1)
  );

  typedef struct { int n; int d; bit own; bit we; } txn_t;

  txn_t q[$];
  txn_t cur;
  bit   cur_v = 0;
  bit   last  = 1;
  int   free_edge = 0;
  int   err_cyc = INF;
  int   cyc = 0;

  // Reference model: at edge e (ending cycle e) an idle port grants; access
  // occupies cycles e+1 .. d, with d = e+2 for writes and e+1+L for reads.
  always @(posedge clk) begin : model
    int e;
    bit cr, lr, win, w;
    txn_t t;
    e = cyc;
    cyc = cyc + 1;
    cr = read | write;
    lr = ld_req;
    if (reset) begin
      cur_v = 0;
      q.delete();
      last = 1;
      free_edge = e + 1;
      err_cyc = INF;
    end else if (e >= free_edge && (cr || lr)) begin
      if (cr && lr) win = ~last;
      else          win = lr;
      last = win;
      w = win ? ld_we : write;
      if (!win && read && write && err_cyc == INF) err_cyc = e + 1;
      t.n = e;
      t.d = w ? e + 2 : e + 1 + L;
      t.own = win;
      t.we = w;
      q.push_back(t);
      cur = t;
      cur_v = 1;
      free_edge = t.d + 1;
    end
  end

  always @(negedge clk) begin : monitor
    logic [7:0] ex, ac;
    txn_t t;
    int k;
    if (cyc >= 1) begin
      k = cyc;
      ex = '0;
      if (cur_v && k >= cur.n + 1 && k <= cur.d) begin
        ex[1] = 1'b1;
        ex[5] = (k < cur.d);
        ex[4] = cur.we && (k == cur.n + 1);
        ex[3] = cur.own;
        if (k == cur.d) begin
          ex[7] = !cur.own;
          ex[6] = cur.own;
          ex[2] = !cur.own && !cur.we;
        end
      end
      ex[0] = (k >= err_cyc);
      ac = {cu_done, ld_done, mem_en, mem_we, addr_sel & ex[1], mdr_ld, busy, err};
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL outputs cycle %0d: got {cu_done,ld_done,mem_en,mem_we,addr_sel,mdr_ld,busy,err}=%b expected %b",
                 k, ac, ex);
      end
      if (cu_done || ld_done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL done cycle %0d: done pulse with no outstanding grant (cu=%b ld=%b)", k, cu_done, ld_done);
        end else begin
          t = q.pop_front();
          if (t.d != k || ld_done !== t.own || cu_done !== !t.own) begin
            errors++;
            $display("FAIL done cycle %0d: got cu=%b ld=%b, expected owner %0d at cycle %0d",
                     k, cu_done, ld_done, t.own, t.d);
          end
        end
      end
    end
  end

  task automatic wait_done(input bit is_ld);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(is_ld ? ld_done : cu_done) && t < 64);
    if (!(is_ld ? ld_done : cu_done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for side %0d within %0d cycles", is_ld, t);
    end
  endtask

  task automatic cu_agent(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if ($urandom_range(0, 1) != 0) write = 1'b1;
      else                           read  = 1'b1;
      wait_done(1'b0);
      read = 1'b0;
      write = 1'b0;
    end
  endtask

  task automatic ld_agent(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      ld_we = ($urandom_range(0, 1) != 0);
      ld_req = 1'b1;
      wait_done(1'b1);
      ld_req = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1; read = 0; write = 0; ld_req = 0; ld_we = 0;
    r1 = 0; w1 = 0; lr1 = 0; lw1 = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Tie with both sides holding write requests: grants alternate, CU first.
    write = 1; ld_req = 1; ld_we = 1;
    repeat (14) @(negedge clk);
    write = 0; ld_req = 0; ld_we = 0;
    repeat (6) @(negedge clk);

    read = 1;  wait_done(1'b0); read = 0;  repeat (3) @(negedge clk);
    write = 1; wait_done(1'b0); write = 0; repeat (3) @(negedge clk);

    read = 1; write = 1; wait_done(1'b0); read = 0; write = 0;
    repeat (4) @(negedge clk);

    // Reset lands while the read is in WAIT.
    read = 1;
    repeat (2) @(negedge clk);
    reset = 1; read = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);

    fork
      cu_agent(25);
      ld_agent(25);
    join
    repeat (6) @(negedge clk);
    chk("scoreboard drained", 8'(q.size()), 8'd0);

    // Latency-1 instance, loader wins the first tie.
    w1 = 1; lr1 = 1; lw1 = 1;
    @(negedge clk);
    chk("l1 tie access", {1'b0, cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1}, 8'b0_0011101);
    lr1 = 0;
    @(negedge clk);
    chk("l1 tie ld_done", {1'b0, cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1}, 8'b0_0100101);
    @(negedge clk);
    chk("l1 tie idle", {4'b0, cu_done1, ld_done1, mem_en1, busy1}, 8'b0);
    @(negedge clk);
    chk("l1 cu access", {1'b0, cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1}, 8'b0_0011001);
    w1 = 0;
    @(negedge clk);
    chk("l1 cu_done", {1'b0, cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1}, 8'b0_1000001);
    repeat (2) @(negedge clk);

    lr1 = 1; lw1 = 0;
    @(negedge clk);
    chk("l1 ld read access", {1'b0, cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1}, 8'b0_0010101);
    lr1 = 0;
    @(negedge clk);
    chk("l1 ld read done", {1'b0, cu_done1, ld_done1, mem_en1, mem_we1, addr_sel1, mdr_ld1, busy1}, 8'b0_0100101);
    @(negedge clk);
    chk("l1 ld read idle", {3'b0, cu_done1, ld_done1, mem_en1, busy1, err1}, 8'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single data-memory port between two requesters: the control state machine (read/write strobes) and the program loader that fills memory before execution.
- Sits between the control unit and the memory block. Drives memory enable, write enable and address-source select, latches read data into MDR, and returns a one-cycle done pulse to the winning requester.
- Fixed-latency memory; the control unit holds its state until done.

Parameters:
- MEM_LATENCY, 2, cycles from mem_en (read) to valid read data; legal range 1..15.
- LD_FIRST_TIE, 0, winner of the first tie after reset: 0 = control unit, 1 = loader.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- read  in  1  control-unit read request, level, held until cu_done
- write  in  1  control-unit write request, level, held until cu_done
- ld_req  in  1  loader request, level, held until ld_done
- ld_we  in  1  loader op: 1 = write, 0 = read; sampled with ld_req
- cu_done  out  1  one-cycle completion pulse to the control unit
- ld_done  out  1  one-cycle completion pulse to the loader
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- addr_sel  out  1  address/data mux: 0 = AR/control unit, 1 = loader
- mdr_ld  out  1  load MDR from memory read data
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error: read and write were both asserted at arbitration

Behaviour:
- Reset: at a clk edge with reset=1 the state goes to IDLE and all outputs go to 0, including err. last_grant is set so the first tie goes to the side chosen by LD_FIRST_TIE. Reset in any state, including mid-access, aborts with no done pulse.
- States: IDLE, ACCESS, WAIT, DONE. All outputs are registered or decoded from the state only; there is no combinational path from requests to outputs.
- IDLE:
  - Requests are sampled. If none are present, stay in IDLE.
  - Control-unit request = read | write.
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not in last_grant wins (round robin); last_grant is updated on grant.
  - On grant, latch owner, op and addr_sel, then go to ACCESS.
- Control-unit op: write=1 means write. If read=1 and write=1 together, the write wins and err is set; err stays high until reset.
- ACCESS (1 cycle):
  - mem_en=1, mem_we=op_is_write, addr_sel=owner.
  - Write: go to DONE.
  - Read with MEM_LATENCY=1: go to DONE.
  - Read with MEM_LATENCY>1: load wait_cnt=MEM_LATENCY-1, go to WAIT.
- WAIT:
  - mem_en=1, mem_we=0, addr_sel held.
  - Decrement wait_cnt each cycle; go to DONE in the cycle wait_cnt reaches 1.
  - wait_cnt width is 4 bits and it never wraps.
- DONE (1 cycle):
  - The owner's done output pulses high.
  - mdr_ld=1 only for a control-unit read. Loader reads do not touch MDR; the loader takes data directly from the memory bus.
  - mem_en=0. Next state is IDLE.
- Latency:
  - Request seen at edge N. ACCESS in cycle N+1.
  - Write: DONE in cycle N+2.
  - Read: DONE in cycle N+1+MEM_LATENCY.
  - IDLE is always re-entered for at least 1 cycle between accesses.
- Request rules:
  - Deassertion after grant does not abort; the access completes and done still pulses.
  - A request still high in IDLE after DONE counts as a new request.
  - A requester must drop its request in the cycle after its done pulse.
- Invariant: cu_done and ld_done are never high together. busy=1 throughout ACCESS, WAIT and DONE.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3);
  - owner constants OWN_CU=1'b0 and OWN_LD=1'b1;
  - the MEM_LATENCY range limits.
- One natural sub-module, rr_arb2: the two-input round-robin arbiter with the last_grant register. It gives a grant and a valid signal in the same cycle.
- The wait counter and FSM stay inline.

Test Plan:
- Read with MEM_LATENCY=2: read=1 at edge 0 -> mem_en high in cycles 1-2, mem_we=0, addr_sel=0. cu_done and mdr_ld high in cycle 3 only. busy low in cycle 4.
- Control-unit write: write=1 at edge 0 -> mem_en=mem_we=1 in cycle 1, cu_done in cycle 2, mdr_ld stays 0.
- Tie, both held, LD_FIRST_TIE=0, writes:
  - First grant goes to the control unit (cu_done in cycle 2), then the loader (ld_done in cycle 5, addr_sel=1), then the control unit again.
  - Grants strictly alternate.
- read=1 and write=1 together -> a write is performed (mem_we=1) and err=1. err stays 1 after the request drops and clears only on reset.
- Reset mid-read: reset=1 during WAIT -> next cycle all outputs are 0 and the state is IDLE. No cu_done ever pulses for the aborted read.
- MEM_LATENCY=1 loader read: ld_req=1, ld_we=0 at edge 0 -> ACCESS in cycle 1, ld_done in cycle 2, mdr_ld=0, WAIT never entered.
